// File: rtl/trp_bit_sequencer.sv
// ============================================================================
// Module  : trp_bit_sequencer
// Brief   : Buffered UART-style frame sequencer (start, 8 data LSB first,
//           stop) driving st/S/M of the trapezoidal modulation generator.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module trp_bit_sequencer #(
  parameter int BIT_CYC = 2500,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic [7:0] din,
  input  logic [5:0] M_in,
  output logic       ready,
  output logic       st,
  output logic       S,
  output logic [5:0] M_out,
  output logic       busy,
  output logic       frame_done,
  output logic       ovf
);

  localparam logic [CNT_W-1:0] c_LAST_CYC = CNT_W'(BIT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_buf_full;
  logic [7:0]       r_buf_data;
  logic [5:0]       r_buf_M;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_idx;
  logic [CNT_W-1:0] r_timer;

  assign ready = ~r_buf_full;
  assign busy  = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_buf_full <= 1'b0;
      r_buf_data <= 8'd0;
      r_buf_M    <= 6'd0;
      r_shift    <= 8'd0;
      r_bit_idx  <= 3'd0;
      r_timer    <= '0;
      st         <= 1'b0;
      S          <= 1'b1;
      M_out      <= 6'd0;
      frame_done <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      st         <= 1'b0;
      frame_done <= 1'b0;
      ovf        <= wr & r_buf_full;

      // A write needs an empty buffer and a drain needs a full one, so the
      // two buffer updates below can never collide on the same edge.
      if (wr && !r_buf_full) begin
        r_buf_data <= din;
        r_buf_M    <= M_in;
        r_buf_full <= 1'b1;
      end

      if (r_state == IDLE) begin
        if (r_buf_full) begin
          r_state    <= START;
          r_shift    <= r_buf_data;
          M_out      <= r_buf_M;
          r_buf_full <= 1'b0;
          S          <= 1'b0;
          st         <= 1'b1;
          r_timer    <= '0;
        end
      end else if (r_timer != c_LAST_CYC) begin
        r_timer <= r_timer + 1'b1;
      end else begin
        r_timer <= '0;
        st      <= 1'b1;
        case (r_state)
          START: begin
            r_state   <= DATA;
            r_bit_idx <= 3'd0;
            S         <= r_shift[0];
          end
          DATA: begin
            if (r_bit_idx == 3'd7) begin
              r_state <= STOP;
              S       <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              S         <= r_shift[r_bit_idx + 3'd1];
            end
          end
          default: begin
            // End of stop bit: chain straight into a queued frame if present.
            frame_done <= 1'b1;
            if (r_buf_full) begin
              r_state    <= START;
              r_shift    <= r_buf_data;
              M_out      <= r_buf_M;
              r_buf_full <= 1'b0;
              S          <= 1'b0;
            end else begin
              r_state <= IDLE;
              S       <= 1'b1;
              st      <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/trp_bit_sequencer.md
Name: trp_bit_sequencer

Overview:
Upstream frame sequencer for the trapezoidal modulation generator. It accepts a data byte and a modulation depth over a one-deep buffered write handshake, then serialises a 10-bit frame: start bit, 8 data bits LSB first, stop bit. For each bit it issues a one-clock start strobe `st` and holds the bit level on `S`, which is the sign input of the generator. `st`, `S` and `M_out` connect directly to the generator's `st`, `S` and `M` inputs.

Parameters:
BIT_CYC, 2500, clk cycles per bit period (= Fclk/BR); legal range 2..65535.
CNT_W, 16, width of the bit timer; must satisfy 2^CNT_W > BIT_CYC-1.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
wr  input  1  write strobe; a write is accepted when wr=1 and ready=1.
din  input  8  frame data byte, transmitted LSB first.
M_in  input  6  modulation depth for this frame.
ready  output  1  holding buffer empty; writes are accepted.
st  output  1  one-cycle strobe at the start of every bit (10 per frame).
S  output  1  current bit level; 1 when idle.
M_out  output  6  depth of the frame in flight; held constant for the whole frame.
busy  output  1  frame in progress (state ≠ IDLE).
frame_done  output  1  one-cycle pulse on the edge that ends the stop bit.
ovf  output  1  one-cycle pulse when wr=1 while ready=0; that write is dropped.

Behaviour:
- Reset (synchronous, rst=1 sampled at posedge):
  - state=IDLE; buf_full=0; ready=1; st=0; S=1; M_out=0; busy=0; frame_done=0; ovf=0; timer=0; bit_idx=0.
  - Reset has priority over all other events, including mid-frame: the frame is aborted, the buffer is cleared, and S=1 after that edge.
- Holding buffer:
  - On wr & ready: buf_data←din, buf_M←M_in, buf_full←1.
  - ready = ~buf_full (registered-derived, no combinational path from wr).
  - wr & ~ready: buffer unchanged; ovf=1 for one cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE & buf_full at an edge → START. On that edge: shift←buf_data; M_out←buf_M; buf_full←0; S←0; st←1; timer←0.
  - Latency: wr accepted at edge n → st=1 and S=0 visible after edge n+1 (two-edge latency from wr).
- Bit timer:
  - Counts 0..BIT_CYC-1 in every non-IDLE state. At timer==BIT_CYC-1 the bit ends; timer←0.
  - Every bit lasts exactly BIT_CYC cycles, measured st-to-st.
- Bit transitions (each bit end asserts st for one cycle on the same edge that updates S):
  - START end → DATA, bit_idx←0, S←shift[0].
  - DATA end with bit_idx<7 → bit_idx+1, S←shift[bit_idx+1].
  - DATA end with bit_idx=7 → STOP, S←1.
  - STOP end: frame_done=1 for one cycle, then:
    - if buf_full: START of the next frame on the same edge (st=1, S=0, new M_out, buffer drained). No idle gap.
    - else: IDLE, S=1, st=0, M_out holds its last value.
- Frame length: exactly 10×BIT_CYC cycles; exactly 10 st pulses.
- st is never asserted in IDLE; st and S change on the same edge.
- A write accepted during a frame is queued and sent back-to-back. Only one frame can be queued; a further write gives ovf.
- No conflict exists between a write and a buffer drain: a write requires buf_full=0, and a drain requires buf_full=1.
- M_in is sampled only on an accepted write. M_out changes only at a frame START.

Test Plan:
1. Reset: rst high for 3 cycles → ready=1, S=1, st=0, busy=0, M_out=0. No st pulses for 100 cycles with wr=0.
2. Single frame, BIT_CYC=8: wr with din=0xA5, M_in=5 → st after 2 edges; 10 st pulses spaced 8 cycles apart.
   - S sequence per bit: 0,1,0,1,0,0,1,0,1,1; M_out=5 throughout.
   - frame_done pulses 80 cycles after the first st; then busy=0, S=1.
3. Back-to-back, BIT_CYC=8: write 0x00 (M=1), then write 0xFF (M=2) during bit 3 → ready=0 until the second frame starts.
   - Second frame's start st comes exactly 8 cycles after the first frame's stop st; no IDLE cycle between frames.
   - M_out switches 1→2 on that edge.
4. Overflow: with a frame in flight and the buffer full, wr with din=0x3C → ovf=1 for one cycle. The queued byte is transmitted, not 0x3C.
5. Reset mid-frame: rst asserted during DATA bit 4 → next cycle S=1, busy=0, ready=1, no frame_done.
   - A new write afterwards produces a clean 10-bit frame.
6. Boundary, BIT_CYC=2: wr with din=0x01 → st on every 2nd cycle for 10 pulses; S=0,1,0,0,0,0,0,0,0,1; frame_done once.
